// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: serve countdown, score keeping and winner detection.
// All outputs are Moore decodes of the state, score and winner registers.
module pong_game_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned WIN_SCORE     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       goal_l,
  input  logic       goal_r,
  input  logic       restart,
  output logic [5:0] score,
  output logic [1:0] pause,
  output logic       ball_hold,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {CD3, CD2, CD1, PLAY, OVER} state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_SEC - 1);
  localparam logic [2:0] WIN       = 3'(WIN_SCORE);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [2:0] left_sc, left_next, right_sc, right_next;
  logic       win_reg, win_next;
  logic [2:0] left_inc, right_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CD3;
      cnt      <= 8'd0;
      left_sc  <= 3'd0;
      right_sc <= 3'd0;
      win_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      left_sc  <= left_next;
      right_sc <= right_next;
      win_reg  <= win_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    left_next  = left_sc;
    right_next = right_sc;
    win_next   = win_reg;
    left_inc   = left_sc + 3'd1;
    right_inc  = right_sc + 3'd1;
    case (state)
      CD3, CD2, CD1: begin
        if (refr_tick) begin
          if (cnt == TICK_LAST) begin
            cnt_next = 8'd0;
            case (state)
              CD3:     state_next = CD2;
              CD2:     state_next = CD1;
              default: state_next = PLAY;
            endcase
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        // Counter is parked at zero here so every countdown starts clean,
        // including a refr_tick that coincides with the goal.
        cnt_next = 8'd0;
        if (goal_l && goal_r) begin
          state_next = CD3;
        end else if (goal_r) begin
          left_next = left_inc;
          if (left_inc == WIN) begin
            state_next = OVER;
            win_next   = 1'b0;
          end else begin
            state_next = CD3;
          end
        end else if (goal_l) begin
          right_next = right_inc;
          if (right_inc == WIN) begin
            state_next = OVER;
            win_next   = 1'b1;
          end else begin
            state_next = CD3;
          end
        end
      end
      OVER: begin
        cnt_next = 8'd0;
        if (restart) begin
          left_next  = 3'd0;
          right_next = 3'd0;
          state_next = CD3;
        end
      end
      default: begin
        state_next = CD3;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_comb begin
    score     = {left_sc, right_sc};
    winner    = win_reg;
    game_over = (state == OVER);
    ball_hold = (state != PLAY);
    case (state)
      CD3:     pause = 2'd3;
      CD2:     pause = 2'd2;
      CD1:     pause = 2'd1;
      default: pause = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, corner-case sequences and
// randomized traffic against an elapsed-tick reference model.
module tb_pong_game_ctrl;

  localparam int TPS = 4;
  localparam int WIN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       refr_tick = 1'b0, goal_l = 1'b0, goal_r = 1'b0, restart = 1'b0;
  logic [5:0] score;
  logic [1:0] pause;
  logic       ball_hold, game_over, winner;

  pong_game_ctrl #(.TICKS_PER_SEC(TPS), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .goal_l(goal_l),
    .goal_r(goal_r), .restart(restart), .score(score), .pause(pause),
    .ball_hold(ball_hold), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: serve progress is counted as total refr_ticks since the
  // serve began; the displayed digit falls out of integer division.
  int m_ticks, m_ls, m_rs;
  bit m_over, m_win;

  typedef struct {
    bit         r, gl, gr, rs;
    logic [5:0] sc;
    logic [1:0] pz;
    logic       hold, over;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0; m_ls = 0; m_rs = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_update(input bit r, input bit gl, input bit gr, input bit rs);
    if (m_over) begin
      if (rs) begin
        m_ls = 0; m_rs = 0; m_over = 0; m_ticks = 0;
      end
    end else if (m_ticks < 3 * TPS) begin
      if (r) m_ticks++;
    end else if (gl && gr) begin
      m_ticks = 0;
    end else if (gr) begin
      m_ls++;
      if (m_ls == WIN) begin m_over = 1; m_win = 0; end
      else m_ticks = 0;
    end else if (gl) begin
      m_rs++;
      if (m_rs == WIN) begin m_over = 1; m_win = 1; end
      else m_ticks = 0;
    end
  endtask

  task automatic check_model();
    int exp_pause;
    bit serving;
    serving   = !m_over && (m_ticks < 3 * TPS);
    exp_pause = serving ? 3 - m_ticks / TPS : 0;
    chk("m_score", {2'b00, score}, {2'b00, m_ls[2:0], m_rs[2:0]});
    chk("m_pause", {6'd0, pause}, 8'(exp_pause));
    chk("m_hold", {7'd0, ball_hold}, {7'd0, (serving || m_over)});
    chk("m_over", {7'd0, game_over}, {7'd0, m_over});
    if (m_over) chk("m_winner", {7'd0, winner}, {7'd0, m_win});
  endtask

  task automatic step(input bit r, input bit gl, input bit gr, input bit rs);
    refr_tick = r; goal_l = gl; goal_r = gr; restart = rs;
    @(posedge clk);
    model_update(r, gl, gr, rs);
    #1;
    check_model();
    refr_tick = 0; goal_l = 0; goal_r = 0; restart = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input bit r, gl, gr, rs, input logic [5:0] sc,
                     input logic [1:0] pz, input logic hold, over);
    vec_t v;
    v.r = r; v.gl = gl; v.gr = gr; v.rs = rs;
    v.sc = sc; v.pz = pz; v.hold = hold; v.over = over;
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 6'o00, 2'd3, 1, 0);
    add(1, 0, 0, 0, 6'o00, 2'd2, 1, 0);
    add(0, 0, 0, 0, 6'o00, 2'd2, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 6'o00, 2'd2, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 6'o00, 2'd1, 1, 0);
    add(1, 0, 0, 0, 6'o00, 2'd0, 0, 0);
    add(0, 0, 1, 0, 6'b001_000, 2'd3, 1, 0);
    add(0, 1, 0, 0, 6'b001_000, 2'd3, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 6'b001_000, 2'd3, 1, 0);
    add(1, 0, 0, 0, 6'b001_000, 2'd2, 1, 0);
    add(0, 1, 0, 0, 6'b001_000, 2'd2, 1, 0);
    add(0, 0, 0, 1, 6'b001_000, 2'd2, 1, 0);

    #3;
    do_reset();
    chk("rst_score", {2'b00, score}, 8'd0);
    chk("rst_pause", {6'd0, pause}, 8'd3);
    chk("rst_hold", {7'd0, ball_hold}, 8'd1);
    chk("rst_over", {7'd0, game_over}, 8'd0);
    chk("rst_winner", {7'd0, winner}, 8'd0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].gl, vq[i].gr, vq[i].rs);
      chk($sformatf("vec%0d_score", i), {2'b00, score}, {2'b00, vq[i].sc});
      chk($sformatf("vec%0d_pause", i), {6'd0, pause}, {6'd0, vq[i].pz});
      chk($sformatf("vec%0d_hold", i), {7'd0, ball_hold}, {7'd0, vq[i].hold});
      chk($sformatf("vec%0d_over", i), {7'd0, game_over}, {7'd0, vq[i].over});
    end

    // Countdown must not move without refr_tick.
    do_reset();
    repeat (1000) step(0, 0, 0, 0);
    chk("idle_pause", {6'd0, pause}, 8'd3);

    // Simultaneous goals replay the serve.
    ticks(12);
    chk("play_hold", {7'd0, ball_hold}, 8'd0);
    step(0, 1, 1, 0);
    chk("both_score", {2'b00, score}, 8'd0);
    chk("both_pause", {6'd0, pause}, 8'd3);

    // Right player wins at WIN_SCORE; OVER holds until restart.
    do_reset();
    ticks(12); step(0, 1, 0, 0);
    ticks(12); step(0, 1, 0, 0);
    ticks(12); step(0, 1, 0, 0);
    chk("win_score", {2'b00, score}, 8'b0000_0011);
    chk("win_over", {7'd0, game_over}, 8'd1);
    chk("win_winner", {7'd0, winner}, 8'd1);
    chk("win_pause", {6'd0, pause}, 8'd0);
    chk("win_hold", {7'd0, ball_hold}, 8'd1);
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    chk("over_goal_score", {2'b00, score}, 8'b0000_0011);
    step(0, 0, 0, 1);
    chk("restart_score", {2'b00, score}, 8'd0);
    chk("restart_over", {7'd0, game_over}, 8'd0);
    chk("restart_pause", {6'd0, pause}, 8'd3);

    // Asynchronous reset in CD2 with counter at 2.
    do_reset();
    ticks(6);
    chk("pre_async_pause", {6'd0, pause}, 8'd2);
    do_reset();
    chk("async_pause", {6'd0, pause}, 8'd3);
    chk("async_hold", {7'd0, ball_hold}, 8'd1);
    ticks(3);
    chk("after_async_3", {6'd0, pause}, 8'd3);
    ticks(1);
    chk("after_async_4", {6'd0, pause}, 8'd2);

    // refr_tick coincident with a goal does not count toward CD3.
    do_reset();
    ticks(12);
    step(1, 0, 1, 0);
    chk("tickgoal_score", {2'b00, score}, 8'b0000_1000);
    ticks(3);
    chk("tickgoal_3", {6'd0, pause}, 8'd3);
    ticks(1);
    chk("tickgoal_4", {6'd0, pause}, 8'd2);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
